// File: rtl/fir_decimate_pkg.sv
`default_nettype none
// Shared fixed-point globals for the audio filter chain: format, helpers,
// low-pass coefficient set and the decimator state encoding.
package fir_decimate_pkg;

    localparam int BITS       = 10;
    localparam int DATA_WIDTH = 32;
    localparam int LPF_TAPS   = 32;

    typedef enum logic [1:0] {
        ST_SHIFT   = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_WRITE   = 2'd2
    } state_t;

    function automatic logic signed [DATA_WIDTH-1:0] quantize(input int value);
        logic signed [DATA_WIDTH-1:0] q;
        q = value;
        return q <<< BITS;
    endfunction

    function automatic int dequantize(input logic signed [DATA_WIDTH-1:0] value);
        return int'(value >>> BITS);
    endfunction

    // Low 2N bits of the product of sign-extended operands equal the signed product.
    function automatic logic signed [DATA_WIDTH-1:0] multiply_truncation(
        input logic signed [DATA_WIDTH-1:0] a,
        input logic signed [DATA_WIDTH-1:0] b
    );
        logic [2*DATA_WIDTH-1:0]        a_ext;
        logic [2*DATA_WIDTH-1:0]        b_ext;
        logic signed [2*DATA_WIDTH-1:0] product;
        logic signed [2*DATA_WIDTH-1:0] shifted;
        a_ext   = {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a};
        b_ext   = {{DATA_WIDTH{b[DATA_WIDTH-1]}}, b};
        product = $signed(a_ext * b_ext);
        shifted = product >>> BITS;
        return shifted[DATA_WIDTH-1:0];
    endfunction

    // Symmetric response, so the concatenation order is immaterial.
    localparam logic [LPF_TAPS-1:0][DATA_WIDTH-1:0] AUDIO_LPF_COEFFS = {
        -32'sd1,   -32'sd2,   -32'sd3,   -32'sd4,
        -32'sd4,   -32'sd2,    32'sd3,    32'sd11,
         32'sd22,   32'sd37,   32'sd54,   32'sd72,
         32'sd89,   32'sd104,  32'sd115,  32'sd121,
         32'sd121,  32'sd115,  32'sd104,  32'sd89,
         32'sd72,   32'sd54,   32'sd37,   32'sd22,
         32'sd11,   32'sd3,   -32'sd2,   -32'sd4,
        -32'sd4,   -32'sd3,   -32'sd2,   -32'sd1
    };

endpackage
`default_nettype wire

// File: rtl/fir_decimate.sv
`default_nettype none
// Decimating FIR: shifts in DECIMATION samples, runs a one-tap-per-cycle MAC
// over the history, then writes one result downstream.
module fir_decimate
    import fir_decimate_pkg::*;
#(
    parameter int DATA_SIZE  = 32,
    parameter int NUM_TAPS   = 32,
    parameter int DECIMATION = 8,
    parameter logic [NUM_TAPS-1:0][DATA_SIZE-1:0] COEFFS = AUDIO_LPF_COEFFS
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_empty,
    output logic                 in_rd_en,
    input  logic [DATA_SIZE-1:0] din,
    input  logic                 out_full,
    output logic                 out_wr_en,
    output logic [DATA_SIZE-1:0] dout
);

    localparam int TAP_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam int CNT_W = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;
    localparam logic [TAP_W-1:0] LAST_TAP    = TAP_W'(NUM_TAPS - 1);
    localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(DECIMATION - 1);

    state_t               state;
    state_t               next_state;
    logic [DATA_SIZE-1:0] shift_reg [NUM_TAPS];
    logic [DATA_SIZE-1:0] acc;
    logic [DATA_SIZE-1:0] tap_sum;
    logic [TAP_W-1:0]     tap_cnt;
    logic [CNT_W-1:0]     sample_cnt;

    assign tap_sum = acc + multiply_truncation(COEFFS[tap_cnt], shift_reg[tap_cnt]);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_SHIFT;
        end else begin
            state <= next_state;
        end
    end

    // Strobes are gated by reset so nothing is consumed or produced while held.
    always_comb begin
        next_state = state;
        in_rd_en   = 1'b0;
        out_wr_en  = 1'b0;
        case (state)
            ST_SHIFT: begin
                in_rd_en = !in_empty && !reset;
                if (!in_empty && (sample_cnt == LAST_SAMPLE)) begin
                    next_state = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                if (tap_cnt == LAST_TAP) begin
                    next_state = ST_WRITE;
                end
            end
            ST_WRITE: begin
                out_wr_en = !out_full && !reset;
                if (!out_full) begin
                    next_state = ST_SHIFT;
                end
            end
            default: next_state = ST_SHIFT;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                shift_reg[i] <= '0;
            end
            acc        <= '0;
            dout       <= '0;
            sample_cnt <= '0;
            tap_cnt    <= '0;
        end else begin
            case (state)
                ST_SHIFT: begin
                    if (!in_empty) begin
                        for (int i = NUM_TAPS - 1; i > 0; i--) begin
                            shift_reg[i] <= shift_reg[i-1];
                        end
                        shift_reg[0] <= din;
                        if (sample_cnt == LAST_SAMPLE) begin
                            sample_cnt <= '0;
                            acc        <= '0;
                            tap_cnt    <= '0;
                        end else begin
                            sample_cnt <= sample_cnt + 1'b1;
                        end
                    end
                end
                ST_COMPUTE: begin
                    acc <= tap_sum;
                    if (tap_cnt == LAST_TAP) begin
                        dout    <= tap_sum;
                        tap_cnt <= '0;
                    end else begin
                        tap_cnt <= tap_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
